commit_unit: RTL and testbench
==============================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- W, 4: retire lanes per cycle.
- PR, 64: physical register count.
- AR, 32: architectural register count.
- ROBW, 5: ROB index width.
- SMAX, 2: maximum stores retired per cycle.
- RCY, 2: recovery cycles after a mispredict.
REQ-002 The block SHALL have one clock and a synchronous active-high reset. The ports are (name, direction, width, meaning); PW = clog2(PR), AW = clog2(AR):
- clock, in, 1, sole clock.
- reset, in, 1, synchronous active-high.
- head_valid / head_complete / head_store / head_branch / head_mispred / head_halt, in, W each, per-lane ROB head flags; lane 0 is oldest.
- head_arch_rd, in, W*AW, destination architectural register.
- head_phys_rd / head_prev_phys, in, W*PW each, new and old physical tags.
- head_idx, in, W*ROBW, ROB index per lane.
- st_ack_cnt, in, clog2(SMAX+1), stores the D-cache accepts this cycle; always <= st_req_cnt.
- st_req_cnt, out, clog2(SMAX+1), stores offered this cycle.
- commit_mask, out, W, lanes committing this cycle.
- arch_we, out, W, arch map write enables.
- arch_addr, out, W*AW, arch map write addresses.
- arch_tag, out, W*PW, arch map write tags.
- free_mask, out, PR, physical registers released.
- restore_mask, out, PR, freelist restore image.
- mispredict, out, 1, flush request.
- mispred_idx, out, ROBW, ROB index of the mispredicted branch.
- halted, out, 1, halt has committed.
- state, out, 2, 0=RUN, 1=RECOVER, 2=HALTED.
- commit_count, out, 32, total committed instructions.

Function
REQ-003 In RUN, the block SHALL scan lanes 0..W-1 in order. It skips lanes that are not valid and stops at the first valid lane that is not complete.
REQ-004 A store lane SHALL be offered only while fewer than SMAX stores are offered earlier in the cycle. st_req_cnt is the number of stores offered before the scan stops.
REQ-005 The k-th offered store (k counted from 1) SHALL commit only if k <= st_ack_cnt. Otherwise the scan stops at that lane, and no younger lane commits.
REQ-006 A committed lane with arch_rd != 0 and not a branch SHALL assert arch_we with arch_rd and phys_rd, and set restore bit phys_rd to 0.
REQ-007 For the same lane, if prev_phys != 0, the block SHALL set free_mask[prev_phys] and restore bit prev_phys to 1.
REQ-008 If the same register is both set and cleared in one cycle, the later lane's write SHALL win.
REQ-009 A committed branch with head_mispred=1 SHALL:
- assert mispredict for one cycle with mispred_idx = head_idx of that lane;
- be the last committed lane of the cycle;
- move the state to RECOVER at the next edge.
REQ-010 A committed lane with head_halt=1 SHALL end the scan after that lane and move the state to HALTED at the next edge.
REQ-011 If one lane is both a mispredicting branch and a halt, mispredict takes precedence and the next state is RECOVER.
REQ-012 RECOVER SHALL last exactly RCY cycles, counted by a down-counter. During RECOVER:
- commit_mask = 0;
- st_req_cnt = 0;
- mispredict = 0.
REQ-013 After RECOVER the state SHALL return to RUN.
REQ-014 HALTED SHALL hold halted=1 and block all commits and store offers until reset.
REQ-015 restore_mask SHALL equal the next-state value of the checkpoint register. The register updates every cycle from the commits of that cycle.
REQ-016 commit_count SHALL add popcount(commit_mask) each cycle and wrap modulo 2^32.
REQ-017 All per-cycle outputs SHALL be combinational from the current state and inputs:
- commit_mask, arch_*, free_mask, st_req_cnt, mispredict, mispred_idx.
REQ-018 state, halted and commit_count SHALL be registered.
REQ-019 An empty head (all head_valid=0) SHALL produce zero commits and leave the state unchanged.

Reset
REQ-020 On reset:
- state = RUN, halted = 0, commit_count = 0;
- the recovery counter is cleared;
- the checkpoint register = bits [AR-1:0] at 0 and bits [PR-1:AR] at 1.
REQ-021 All combinational outputs SHALL be 0 in the cycle reset is asserted.
REQ-022 Reset during RECOVER or HALTED SHALL return the block to RUN on the next edge.

Verification
REQ-023 W=4, four complete ALU lanes with arch_rd 1,2,3,4, phys 40..43, prev 1..4 -> commit_mask=1111, free_mask bits 1..4 set, commit_count +4.
REQ-024 Lane 1 not complete -> commit_mask=0001; lanes 2 and 3 do not commit even though they are complete.
REQ-025 Three complete stores, st_ack_cnt=1 -> st_req_cnt=2, commit_mask=0001. Next cycle lanes 0,1 are stores and st_ack_cnt=2 -> commit_mask=0011.
REQ-026 Lane 1 is a mispredicted branch with head_idx=7 -> commit_mask=0011, mispredict=1, mispred_idx=7. The next RCY=2 cycles have commit_mask=0 and state=1, then state=0.
REQ-027 Lane 2 is a halt -> commit_mask=0111, then halted=1 and state=2, with no commits while complete lanes are presented. Reset -> state=0 and commit_count=0.
REQ-028 Lane 0 writes arch 5 / phys 50 with prev 20, and lane 1 writes arch 6 with prev 50 -> restore_mask bit 50=1, bit 20=1, free_mask bits 20 and 50 set.

Source files
------------

// File: rtl/commit_unit.sv
// In-order retirement stage: scans the ROB head lanes, commits a contiguous prefix,
// arbitrates store retirement, maintains the freelist checkpoint and the RUN/RECOVER/HALTED state.
module commit_unit #(
  parameter int W    = 4,
  parameter int PR   = 64,
  parameter int AR   = 32,
  parameter int ROBW = 5,
  parameter int SMAX = 2,
  parameter int RCY  = 2,
  localparam int PW  = $clog2(PR),
  localparam int AW  = $clog2(AR),
  localparam int SW  = $clog2(SMAX + 1),
  localparam int CW  = $clog2(RCY + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [W-1:0]      head_valid,
  input  logic [W-1:0]      head_complete,
  input  logic [W-1:0]      head_store,
  input  logic [W-1:0]      head_branch,
  input  logic [W-1:0]      head_mispred,
  input  logic [W-1:0]      head_halt,
  input  logic [W*AW-1:0]   head_arch_rd,
  input  logic [W*PW-1:0]   head_phys_rd,
  input  logic [W*PW-1:0]   head_prev_phys,
  input  logic [W*ROBW-1:0] head_idx,
  input  logic [SW-1:0]     st_ack_cnt,
  output logic [SW-1:0]     st_req_cnt,
  output logic [W-1:0]      commit_mask,
  output logic [W-1:0]      arch_we,
  output logic [W*AW-1:0]   arch_addr,
  output logic [W*PW-1:0]   arch_tag,
  output logic [PR-1:0]     free_mask,
  output logic [PR-1:0]     restore_mask,
  output logic              mispredict,
  output logic [ROBW-1:0]   mispred_idx,
  output logic              halted,
  output logic [1:0]        state,
  output logic [31:0]       commit_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  localparam logic [PR-1:0] CKPT_INIT = {{(PR-AR){1'b1}}, {AR{1'b0}}};

  state_t          state_r;
  logic            halted_r;
  logic [31:0]     commit_count_r;
  logic [CW-1:0]   rcy_cnt_r;
  logic [PR-1:0]   ckpt_r;
  logic [PR-1:0]   ckpt_next_s;
  logic            halt_s;

  function automatic logic [31:0] popcount(input logic [W-1:0] m);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < W; i++) begin
      n = n + {31'd0, m[i]};
    end
    return n;
  endfunction

  // Head scan: decides the committing prefix and all per-cycle side effects.
  always_comb begin : scan
    logic          stop_s;
    logic          take_s;
    logic [SW-1:0] offered_s;
    logic [PW-1:0] phys_s;
    logic [PW-1:0] prev_s;
    stop_s      = 1'b0;
    take_s      = 1'b0;
    offered_s   = '0;
    phys_s      = '0;
    prev_s      = '0;
    commit_mask = '0;
    arch_we     = '0;
    arch_addr   = '0;
    arch_tag    = '0;
    free_mask   = '0;
    mispredict  = 1'b0;
    mispred_idx = '0;
    halt_s      = 1'b0;
    ckpt_next_s = ckpt_r;
    if (!reset && state_r == ST_RUN) begin
      for (int i = 0; i < W; i++) begin
        take_s = 1'b0;
        if (stop_s || !head_valid[i]) begin
          take_s = 1'b0;
        end else if (!head_complete[i]) begin
          stop_s = 1'b1;
        end else if (head_store[i]) begin
          // An offered but unacknowledged store blocks every younger lane.
          if (offered_s < SW'(SMAX)) begin
            offered_s = offered_s + SW'(1);
            if (offered_s <= st_ack_cnt) begin
              take_s = 1'b1;
            end else begin
              stop_s = 1'b1;
            end
          end else begin
            stop_s = 1'b1;
          end
        end else begin
          take_s = 1'b1;
        end
        if (take_s) begin
          commit_mask[i] = 1'b1;
          phys_s = head_phys_rd[i*PW +: PW];
          prev_s = head_prev_phys[i*PW +: PW];
          if (head_arch_rd[i*AW +: AW] != '0 && !head_branch[i]) begin
            arch_we[i]              = 1'b1;
            arch_addr[i*AW +: AW]   = head_arch_rd[i*AW +: AW];
            arch_tag[i*PW +: PW]    = phys_s;
            ckpt_next_s[phys_s]     = 1'b0;
            free_mask[prev_s]       = free_mask[prev_s] | (prev_s != '0);
            ckpt_next_s[prev_s]     = ckpt_next_s[prev_s] | (prev_s != '0);
          end else begin
            arch_we[i] = 1'b0;
          end
          if (head_branch[i] && head_mispred[i]) begin
            mispredict  = 1'b1;
            mispred_idx = head_idx[i*ROBW +: ROBW];
            stop_s      = 1'b1;
          end else if (head_halt[i]) begin
            halt_s = 1'b1;
            stop_s = 1'b1;
          end else begin
            stop_s = 1'b0;
          end
        end else begin
          commit_mask[i] = 1'b0;
        end
      end
      st_req_cnt = offered_s;
    end else begin
      st_req_cnt = '0;
    end
  end

  assign restore_mask = reset ? '0 : ckpt_next_s;
  assign state        = state_r;
  assign halted       = halted_r;
  assign commit_count = commit_count_r;

  // State machine, recovery counter, checkpoint and retirement counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_RUN;
      halted_r       <= 1'b0;
      commit_count_r <= 32'd0;
      rcy_cnt_r      <= '0;
      ckpt_r         <= CKPT_INIT;
    end else begin
      ckpt_r         <= ckpt_next_s;
      commit_count_r <= commit_count_r + popcount(commit_mask);
      case (state_r)
        ST_RUN: begin
          if (mispredict) begin
            state_r   <= ST_RECOVER;
            rcy_cnt_r <= CW'(RCY);
          end else if (halt_s) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end
        end
        ST_RECOVER: begin
          rcy_cnt_r <= rcy_cnt_r - CW'(1);
          if (rcy_cnt_r == CW'(1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED: halted_r <= 1'b1;
        default:   state_r  <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios plus randomized head contents
// checked against a rule-level retirement model.
module tb_commit_unit;
  localparam int W = 4, PR = 64, AR = 32, ROBW = 5, SMAX = 2, RCY = 2;
  localparam int AW = 5, PW = 6, SW = 2;

  logic clock = 1'b0;
  logic reset;
  logic [W-1:0] head_valid, head_complete, head_store, head_branch, head_mispred, head_halt;
  logic [W*AW-1:0] head_arch_rd;
  logic [W*PW-1:0] head_phys_rd, head_prev_phys;
  logic [W*ROBW-1:0] head_idx;
  logic [SW-1:0] st_ack_cnt, st_req_cnt;
  logic [W-1:0] commit_mask, arch_we;
  logic [W*AW-1:0] arch_addr;
  logic [W*PW-1:0] arch_tag;
  logic [PR-1:0] free_mask, restore_mask;
  logic mispredict, halted;
  logic [ROBW-1:0] mispred_idx;
  logic [1:0] state;
  logic [31:0] commit_count;

  commit_unit #(.W(W), .PR(PR), .AR(AR), .ROBW(ROBW), .SMAX(SMAX), .RCY(RCY)) dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_complete(head_complete), .head_store(head_store),
    .head_branch(head_branch), .head_mispred(head_mispred), .head_halt(head_halt),
    .head_arch_rd(head_arch_rd), .head_phys_rd(head_phys_rd), .head_prev_phys(head_prev_phys),
    .head_idx(head_idx), .st_ack_cnt(st_ack_cnt), .st_req_cnt(st_req_cnt),
    .commit_mask(commit_mask), .arch_we(arch_we), .arch_addr(arch_addr), .arch_tag(arch_tag),
    .free_mask(free_mask), .restore_mask(restore_mask), .mispredict(mispredict),
    .mispred_idx(mispred_idx), .halted(halted), .state(state), .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Lane stimulus, as plain per-lane fields
  bit l_valid[W], l_complete[W], l_store[W], l_branch[W], l_mispred[W], l_halt[W];
  int l_ard[W], l_prd[W], l_prev[W], l_idx[W];
  int l_ack;

  // Reference model state and expectations
  int m_state, m_rcy;
  bit [31:0] m_count;
  bit [PR-1:0] m_ckpt;
  bit m_halt_now;
  logic [W-1:0] exp_commit, exp_we;
  logic [W*AW-1:0] exp_addr;
  logic [W*PW-1:0] exp_tag;
  logic [PR-1:0] exp_free, exp_restore;
  logic [SW-1:0] exp_req;
  logic exp_mp;
  logic [ROBW-1:0] exp_mpidx;

  task automatic clear_lanes();
    for (int i = 0; i < W; i++) begin
      l_valid[i] = 0; l_complete[i] = 0; l_store[i] = 0; l_branch[i] = 0;
      l_mispred[i] = 0; l_halt[i] = 0; l_ard[i] = 0; l_prd[i] = 0; l_prev[i] = 0; l_idx[i] = 0;
    end
    l_ack = 0;
  endtask

  task automatic set_lane(input int i, input int ard, input int prd, input int prev);
    l_valid[i] = 1; l_complete[i] = 1; l_ard[i] = ard; l_prd[i] = prd; l_prev[i] = prev;
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      head_valid[i] = l_valid[i]; head_complete[i] = l_complete[i]; head_store[i] = l_store[i];
      head_branch[i] = l_branch[i]; head_mispred[i] = l_mispred[i]; head_halt[i] = l_halt[i];
      head_arch_rd[i*AW +: AW] = l_ard[i][AW-1:0];
      head_phys_rd[i*PW +: PW] = l_prd[i][PW-1:0];
      head_prev_phys[i*PW +: PW] = l_prev[i][PW-1:0];
      head_idx[i*ROBW +: ROBW] = l_idx[i][ROBW-1:0];
    end
    st_ack_cnt = l_ack[SW-1:0];
  endtask

  // Walk the valid lanes oldest-first applying the retirement rules.
  task automatic model_eval();
    int stores;
    stores = 0;
    exp_commit = '0; exp_we = '0; exp_addr = '0; exp_tag = '0; exp_free = '0;
    exp_mp = 1'b0; exp_mpidx = '0; m_halt_now = 1'b0; exp_req = '0;
    exp_restore = m_ckpt;
    if (reset) begin
      exp_restore = '0;
      return;
    end
    if (m_state != 0) return;
    for (int i = 0; i < W; i++) begin
      if (!l_valid[i]) continue;
      if (!l_complete[i]) break;
      if (l_store[i]) begin
        if (stores == SMAX) break;
        stores++;
        if (stores > l_ack) break;
      end
      exp_commit[i] = 1'b1;
      if (l_ard[i] != 0 && !l_branch[i]) begin
        exp_we[i] = 1'b1;
        exp_addr[i*AW +: AW] = l_ard[i][AW-1:0];
        exp_tag[i*PW +: PW] = l_prd[i][PW-1:0];
        exp_restore[l_prd[i]] = 1'b0;
        if (l_prev[i] != 0) begin
          exp_free[l_prev[i]] = 1'b1;
          exp_restore[l_prev[i]] = 1'b1;
        end
      end
      if (l_branch[i] && l_mispred[i]) begin
        exp_mp = 1'b1; exp_mpidx = l_idx[i][ROBW-1:0];
        break;
      end
      if (l_halt[i]) begin
        m_halt_now = 1'b1;
        break;
      end
    end
    exp_req = SW'(stores);
  endtask

  task automatic model_commit();
    if (reset) begin
      m_state = 0; m_rcy = 0; m_count = 32'd0;
      m_ckpt = {{(PR-AR){1'b1}}, {AR{1'b0}}};
    end else begin
      m_ckpt = exp_restore;
      m_count = m_count + 32'($countones(exp_commit));
      if (m_state == 0) begin
        if (exp_mp) begin m_state = 1; m_rcy = RCY; end
        else if (m_halt_now) m_state = 2;
      end else if (m_state == 1) begin
        m_rcy--;
        if (m_rcy == 0) m_state = 0;
      end
    end
  endtask

  task automatic settle();
    drive();
    model_eval();
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_lanes(); set_lane(0, 1, 40, 1);
    settle();
    n_cmp++; if (commit_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_commit: got %b want 0000", commit_mask); end
    n_cmp++; if (free_mask !== 64'd0 || restore_mask !== 64'd0) begin n_bad++; $display("FAIL reset_masks: free %h restore %h want 0", free_mask, restore_mask); end
    n_cmp++; if (st_req_cnt !== 2'd0 || mispredict !== 1'b0 || arch_we !== 4'b0000) begin n_bad++; $display("FAIL reset_misc: req %0d mp %b we %b want 0", st_req_cnt, mispredict, arch_we); end
    tick();
    n_cmp++; if (state !== 2'd0 || halted !== 1'b0 || commit_count !== 32'd0) begin n_bad++; $display("FAIL reset_regs: state %0d halted %b count %0d want 0/0/0", state, halted, commit_count); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    clear_lanes();
    for (int i = 0; i < W; i++) set_lane(i, i + 1, 40 + i, i + 1);
    settle();
    n_cmp++; if (commit_mask !== 4'b1111) begin n_bad++; $display("FAIL alu_commit: got %b want 1111", commit_mask); end
    n_cmp++; if (free_mask !== 64'h1E) begin n_bad++; $display("FAIL alu_free: got %h want 1e", free_mask); end
    n_cmp++; if (arch_we !== 4'b1111 || arch_addr !== {5'd4, 5'd3, 5'd2, 5'd1} || arch_tag !== {6'd43, 6'd42, 6'd41, 6'd40}) begin
      n_bad++; $display("FAIL alu_arch: we %b addr %h tag %h", arch_we, arch_addr, arch_tag); end
    tick();
    n_cmp++; if (commit_count !== 32'd4) begin n_bad++; $display("FAIL alu_count: got %0d want 4", commit_count); end
  endtask

  task automatic test_stall();
    clear_lanes();
    for (int i = 0; i < W; i++) set_lane(i, 0, 0, 0);
    l_complete[1] = 0;
    settle();
    n_cmp++; if (commit_mask !== 4'b0001) begin n_bad++; $display("FAIL stall_commit: got %b want 0001", commit_mask); end
    tick();
  endtask

  task automatic test_stores();
    clear_lanes();
    for (int i = 0; i < 3; i++) begin set_lane(i, 0, 0, 0); l_store[i] = 1; end
    l_ack = 1;
    settle();
    n_cmp++; if (st_req_cnt !== 2'd2) begin n_bad++; $display("FAIL store_req: got %0d want 2", st_req_cnt); end
    n_cmp++; if (commit_mask !== 4'b0001) begin n_bad++; $display("FAIL store_commit1: got %b want 0001", commit_mask); end
    tick();
    clear_lanes();
    for (int i = 0; i < 2; i++) begin set_lane(i, 0, 0, 0); l_store[i] = 1; end
    l_ack = 2;
    settle();
    n_cmp++; if (commit_mask !== 4'b0011 || st_req_cnt !== 2'd2) begin n_bad++; $display("FAIL store_commit2: got %b req %0d want 0011 req 2", commit_mask, st_req_cnt); end
    tick();
  endtask

  task automatic test_mispredict();
    clear_lanes();
    for (int i = 0; i < W; i++) set_lane(i, 0, 0, 0);
    l_branch[1] = 1; l_mispred[1] = 1; l_idx[1] = 7;
    settle();
    n_cmp++; if (commit_mask !== 4'b0011) begin n_bad++; $display("FAIL mp_commit: got %b want 0011", commit_mask); end
    n_cmp++; if (mispredict !== 1'b1 || mispred_idx !== 5'd7) begin n_bad++; $display("FAIL mp_flag: mp %b idx %0d want 1 idx 7", mispredict, mispred_idx); end
    for (int c = 0; c < RCY; c++) begin
      tick();
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL mp_recover_state: cycle %0d got %0d want 1", c, state); end
      settle();
      n_cmp++; if (commit_mask !== 4'b0000 || mispredict !== 1'b0 || st_req_cnt !== 2'd0) begin
        n_bad++; $display("FAIL mp_recover_quiet: cycle %0d commit %b mp %b req %0d want 0", c, commit_mask, mispredict, st_req_cnt); end
    end
    tick();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mp_return: got %0d want 0", state); end
  endtask

  task automatic test_halt();
    clear_lanes();
    for (int i = 0; i < W; i++) set_lane(i, 0, 0, 0);
    l_halt[2] = 1;
    settle();
    n_cmp++; if (commit_mask !== 4'b0111) begin n_bad++; $display("FAIL halt_commit: got %b want 0111", commit_mask); end
    tick();
    n_cmp++; if (state !== 2'd2 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_state: state %0d halted %b want 2/1", state, halted); end
    l_halt[2] = 0;
    settle();
    n_cmp++; if (commit_mask !== 4'b0000 || st_req_cnt !== 2'd0) begin n_bad++; $display("FAIL halt_block: commit %b req %0d want 0", commit_mask, st_req_cnt); end
    tick();
    reset = 1'b1;
    settle();
    tick();
    n_cmp++; if (state !== 2'd0 || commit_count !== 32'd0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_reset: state %0d count %0d halted %b want 0/0/0", state, commit_count, halted); end
    reset = 1'b0;
  endtask

  task automatic test_restore();
    clear_lanes();
    set_lane(0, 5, 50, 20);
    set_lane(1, 6, 51, 50);
    settle();
    n_cmp++; if (free_mask !== ((64'd1 << 20) | (64'd1 << 50))) begin n_bad++; $display("FAIL restore_free: got %h want bits 20,50", free_mask); end
    n_cmp++; if (restore_mask[50] !== 1'b1 || restore_mask[20] !== 1'b1 || restore_mask[51] !== 1'b0) begin
      n_bad++; $display("FAIL restore_bits: b50 %b b20 %b b51 %b want 1 1 0", restore_mask[50], restore_mask[20], restore_mask[51]); end
    tick();
  endtask

  task automatic test_random();
    int full;
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(99, 0) < 3) || (m_state == 2 && $urandom_range(9, 0) < 3);
      for (int i = 0; i < W; i++) begin
        l_valid[i] = ($urandom_range(9, 0) < 8); l_complete[i] = ($urandom_range(9, 0) < 8);
        l_store[i] = ($urandom_range(3, 0) == 0); l_branch[i] = ($urandom_range(6, 0) == 0);
        l_mispred[i] = ($urandom_range(2, 0) == 0); l_halt[i] = ($urandom_range(49, 0) == 0);
        l_ard[i] = $urandom_range(AR - 1, 0); l_prd[i] = $urandom_range(PR - 1, 0);
        l_prev[i] = $urandom_range(PR - 1, 0); l_idx[i] = $urandom_range(31, 0);
      end
      l_ack = SMAX;
      model_eval();
      full = int'(exp_req);
      l_ack = $urandom_range(full, 0);
      settle();
      n_cmp++; if (commit_mask !== exp_commit) begin n_bad++; $display("FAIL rnd_commit: c%0d got %b want %b", c, commit_mask, exp_commit); end
      n_cmp++; if (st_req_cnt !== exp_req) begin n_bad++; $display("FAIL rnd_req: c%0d got %0d want %0d", c, st_req_cnt, exp_req); end
      n_cmp++; if (arch_we !== exp_we || arch_addr !== exp_addr || arch_tag !== exp_tag) begin
        n_bad++; $display("FAIL rnd_arch: c%0d we %b/%b addr %h/%h tag %h/%h", c, arch_we, exp_we, arch_addr, exp_addr, arch_tag, exp_tag); end
      n_cmp++; if (free_mask !== exp_free) begin n_bad++; $display("FAIL rnd_free: c%0d got %h want %h", c, free_mask, exp_free); end
      n_cmp++; if (restore_mask !== exp_restore) begin n_bad++; $display("FAIL rnd_restore: c%0d got %h want %h", c, restore_mask, exp_restore); end
      n_cmp++; if (mispredict !== exp_mp || mispred_idx !== exp_mpidx) begin
        n_bad++; $display("FAIL rnd_mp: c%0d got %b/%0d want %b/%0d", c, mispredict, mispred_idx, exp_mp, exp_mpidx); end
      tick();
      n_cmp++; if (state !== 2'(m_state) || halted !== (m_state == 2) || commit_count !== m_count) begin
        n_bad++; $display("FAIL rnd_regs: c%0d state %0d/%0d halted %b count %0d/%0d", c, state, m_state, halted, commit_count, m_count); end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_state = 0; m_rcy = 0; m_count = 32'd0; m_ckpt = '0;
    reset = 1'b1;
    clear_lanes();
    drive();
    #1;
    test_reset();
    test_alu();
    test_stall();
    test_stores();
    test_mispredict();
    test_halt();
    test_restore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
